// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 32-bit asynchronous SRAM built from two 16-bit chips.
// Every access walks IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> DONE and returns one ack pulse.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter bit FAIR        = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [17:0] m0_addr,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [17:0] m1_addr,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic [17:0] ram_addr,
   input  logic [31:0] ram_data_read,
   output logic [31:0] ram_data_write,
   output logic        ram_data_is_output,
   output logic [1:0]  ram_ce_n,
   output logic [1:0]  ram_ub_n,
   output logic [1:0]  ram_lb_n,
   output logic        ram_we_n,
   output logic        ram_oe_n
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        grant_reg, grant_next;
   logic        we_reg;
   logic [17:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata0_reg, rdata1_reg;
   logic        take;
   logic        active;
   logic        last_strobe;
   logic        sel_we;
   logic [17:0] sel_addr;
   logic [3:0]  sel_be;
   logic [31:0] sel_wdata;

   // grant_reg doubles as "last granted port"; it resets to 1 so port 0 wins first.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      grant_next = grant_reg;
      take       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (m0_req || m1_req) begin
               take       = 1'b1;
               state_next = SETUP;
               if (m0_req && m1_req)
                  grant_next = FAIR ? ~grant_reg : 1'b0;
               else
                  grant_next = m1_req;
            end
         end
         SETUP: begin
            state_next = STROBE;
            cnt_next   = 4'(WAIT_CYCLES - 1);
         end
         STROBE: begin
            if (cnt_reg == 4'd0)
               state_next = DONE;
            else
               cnt_next = cnt_reg - 4'd1;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sel_we      = grant_next ? m1_we    : m0_we;
   assign sel_addr    = grant_next ? m1_addr  : m0_addr;
   assign sel_be      = grant_next ? m1_be    : m0_be;
   assign sel_wdata   = grant_next ? m1_wdata : m0_wdata;
   assign last_strobe = (state_reg == STROBE) && (cnt_reg == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         grant_reg  <= 1'b1;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         be_reg     <= '0;
         wdata_reg  <= '0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         grant_reg <= grant_next;
         if (take) begin
            we_reg    <= sel_we;
            addr_reg  <= sel_addr;
            be_reg    <= sel_be;
            wdata_reg <= sel_wdata;
         end
         // Read data is sampled on the edge that closes the strobe window.
         if (last_strobe && !we_reg) begin
            if (grant_reg)
               rdata1_reg <= ram_data_read;
            else
               rdata0_reg <= ram_data_read;
         end
      end
   end

   assign active = (state_reg != IDLE);

   for (genvar gi = 0; gi < 2; gi++) begin : g_chip
      assign ram_ce_n[gi] = ~(active && (be_reg[2*gi] || be_reg[2*gi+1]));
      assign ram_ub_n[gi] = ~(active && be_reg[2*gi+1]);
      assign ram_lb_n[gi] = ~(active && be_reg[2*gi]);
   end

   assign ram_addr           = addr_reg;
   assign ram_data_write     = wdata_reg;
   assign ram_data_is_output = active && we_reg;
   assign ram_we_n           = ~((state_reg == STROBE) && we_reg && (|be_reg));
   assign ram_oe_n           = ~(((state_reg == SETUP) || (state_reg == STROBE)) && !we_reg);

   assign m0_ack   = (state_reg == DONE) && !grant_reg;
   assign m1_ack   = (state_reg == DONE) && grant_reg;
   assign m0_rdata = rdata0_reg;
   assign m1_rdata = rdata1_reg;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance 0 is WAIT_CYCLES=1/FAIR=1, instance 1 is WAIT_CYCLES=3/FAIR=0.
// A word-array SRAM model per instance plus a reference memory and grant predictor.
module tb_sram_arbiter;
   logic clk;
   logic reset_n;
   logic preload;

   logic        req   [2][2];
   logic        we    [2][2];
   logic [17:0] addr  [2][2];
   logic [3:0]  be    [2][2];
   logic [31:0] wdata [2][2];
   logic        ack   [2][2];
   logic [31:0] rdata [2][2];

   logic [17:0] ram_addr [2];
   logic [31:0] ram_rd   [2];
   logic [31:0] ram_wr   [2];
   logic        ram_dio  [2];
   logic [1:0]  ram_ce_n [2];
   logic [1:0]  ram_ub_n [2];
   logic [1:0]  ram_lb_n [2];
   logic        ram_we_n [2];
   logic        ram_oe_n [2];

   logic [31:0] ref_mem [2][256];
   int total = 0;
   int bad   = 0;
   int last_a;

   int       mon_we_low, mon_oe_low;
   logic [1:0] mon_ce_first, mon_ub_first, mon_lb_first, mon_ce_and;
   logic     mon_conflict;

   function automatic logic [31:0] pat(input int i, input int j);
      return {8'(j), 8'(~j), 8'(j * 3 + 1), 8'(i + 90)};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      logic [31:0] mem [256];

      sram_arbiter #(
         .WAIT_CYCLES(gi == 0 ? 1 : 3),
         .FAIR(gi == 0 ? 1'b1 : 1'b0)
      ) dut (
         .clk(clk),
         .reset_n(reset_n),
         .m0_req(req[gi][0]),
         .m0_we(we[gi][0]),
         .m0_addr(addr[gi][0]),
         .m0_be(be[gi][0]),
         .m0_wdata(wdata[gi][0]),
         .m0_ack(ack[gi][0]),
         .m0_rdata(rdata[gi][0]),
         .m1_req(req[gi][1]),
         .m1_we(we[gi][1]),
         .m1_addr(addr[gi][1]),
         .m1_be(be[gi][1]),
         .m1_wdata(wdata[gi][1]),
         .m1_ack(ack[gi][1]),
         .m1_rdata(rdata[gi][1]),
         .ram_addr(ram_addr[gi]),
         .ram_data_read(ram_rd[gi]),
         .ram_data_write(ram_wr[gi]),
         .ram_data_is_output(ram_dio[gi]),
         .ram_ce_n(ram_ce_n[gi]),
         .ram_ub_n(ram_ub_n[gi]),
         .ram_lb_n(ram_lb_n[gi]),
         .ram_we_n(ram_we_n[gi]),
         .ram_oe_n(ram_oe_n[gi])
      );

      assign ram_rd[gi] = mem[ram_addr[gi][7:0]];

      // Two 16-bit chips; chip c owns data[16c+15:16c], lb = low byte, ub = high byte.
      always @(posedge clk) begin
         if (preload) begin
            for (int j = 0; j < 256; j++) mem[j] <= pat(gi, j);
         end else if (!ram_we_n[gi]) begin
            for (int c = 0; c < 2; c++) begin
               if (!ram_ce_n[gi][c]) begin
                  if (!ram_lb_n[gi][c]) mem[ram_addr[gi][7:0]][16*c +: 8] <= ram_wr[gi][16*c +: 8];
                  if (!ram_ub_n[gi][c]) mem[ram_addr[gi][7:0]][16*c+8 +: 8] <= ram_wr[gi][16*c+8 +: 8];
               end
            end
         end
      end
   end

   task automatic ref_write(input int i, input logic [17:0] a, input logic [3:0] b, input logic [31:0] d);
      for (int n = 0; n < 4; n++)
         if (b[n]) ref_mem[i][a[7:0]][8*n +: 8] = d[8*n +: 8];
   endtask

   // One access from an idle arbiter; lat counts clock edges from the request-sampling edge to the ack cycle.
   task automatic access(input int i, input int p, input logic w, input logic [17:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
      @(posedge clk); #1;
      we[i][p] = w; addr[i][p] = a; be[i][p] = b; wdata[i][p] = d; req[i][p] = 1'b1;
      lat = 0; mon_we_low = 0; mon_oe_low = 0; mon_ce_and = 2'b11; mon_conflict = 1'b0;
      mon_ce_first = 2'b11; mon_ub_first = 2'b11; mon_lb_first = 2'b11;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!ram_we_n[i]) mon_we_low++;
         if (!ram_oe_n[i]) mon_oe_low++;
         if ((!ram_we_n[i] && !ram_oe_n[i]) || (ram_dio[i] && !ram_oe_n[i])) mon_conflict = 1'b1;
         if (lat == 1) begin
            mon_ce_first = ram_ce_n[i]; mon_ub_first = ram_ub_n[i]; mon_lb_first = ram_lb_n[i];
         end
         mon_ce_and &= ram_ce_n[i];
         we[i][1-p] = 1'($urandom); addr[i][1-p] = 18'($urandom);
         be[i][1-p] = 4'($urandom); wdata[i][1-p] = $urandom;
      end while (!ack[i][p] && lat < 64);
      rd = rdata[i][p];
      req[i][p] = 1'b0;
      if (i == 0 && ack[i][p]) last_a = p;
      $display("txn inst=%0d port=%0d we=%0d addr=%05h be=%h wdata=%08h rdata=%08h lat=%0d",
               i, p, w, a, b, d, rd, lat);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) req[i][p] = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      last_a = 1;
   endtask

   task automatic test_reset();
      preload = 1'b1;
      reset_n = 1'b0;
      last_a  = 1;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; be[i][p] = '0; wdata[i][p] = '0;
         end
      end
      for (int i = 0; i < 2; i++) for (int j = 0; j < 256; j++) ref_mem[i][j] = pat(i, j);
      @(posedge clk); @(posedge clk); #1;
      preload = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({ram_ce_n[i], ram_ub_n[i], ram_lb_n[i], ram_we_n[i], ram_oe_n[i], ram_dio[i]} !== 9'b111111110) begin
            bad++;
            $display("FAIL reset_ctrl[%0d]: got %b want 111111110", i,
                     {ram_ce_n[i], ram_ub_n[i], ram_lb_n[i], ram_we_n[i], ram_oe_n[i], ram_dio[i]});
         end
         total++;
         if ({ram_addr[i], ram_wr[i]} !== 50'd0) begin
            bad++; $display("FAIL reset_bus[%0d]: got addr=%h wdata=%h want 0", i, ram_addr[i], ram_wr[i]);
         end
         total++;
         if ({ack[i][0], ack[i][1]} !== 2'b00) begin
            bad++; $display("FAIL reset_ack[%0d]: got %b%b want 00", i, ack[i][0], ack[i][1]);
         end
         total++;
         if ({rdata[i][0], rdata[i][1]} !== 64'd0) begin
            bad++; $display("FAIL reset_rdata[%0d]: got %h %h want 0", i, rdata[i][0], rdata[i][1]);
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat;
      logic [31:0] rd;
      access(0, 0, 1'b1, 18'h00010, 4'hF, 32'hDEADBEEF, lat, rd);
      ref_write(0, 18'h00010, 4'hF, 32'hDEADBEEF);
      total++; if (lat != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
      total++; if (mon_we_low != 1) begin bad++; $display("FAIL wr_we_low: got %0d want 1", mon_we_low); end
      total++; if (mon_ce_first !== 2'b00) begin bad++; $display("FAIL wr_ce: got %b want 00", mon_ce_first); end
      total++; if (mon_conflict !== 1'b0) begin bad++; $display("FAIL wr_conflict: got 1 want 0"); end
      @(posedge clk); #1;
      total++;
      if ({ram_ce_n[0], ram_ub_n[0], ram_lb_n[0], ram_we_n[0], ram_oe_n[0], ram_dio[0]} !== 9'b111111110) begin
         bad++;
         $display("FAIL idle_ctrl: got %b want 111111110",
                  {ram_ce_n[0], ram_ub_n[0], ram_lb_n[0], ram_we_n[0], ram_oe_n[0], ram_dio[0]});
      end
      access(0, 0, 1'b0, 18'h00010, 4'hF, 32'h0, lat, rd);
      total++; if (lat != 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      total++; if (mon_oe_low != 2) begin bad++; $display("FAIL rd_oe_low: got %0d want 2", mon_oe_low); end
   endtask

   task automatic test_byte_lane();
      int lat;
      logic [31:0] rd;
      access(0, 1, 1'b1, 18'h00020, 4'hF, 32'h11223344, lat, rd);
      ref_write(0, 18'h00020, 4'hF, 32'h11223344);
      access(0, 1, 1'b1, 18'h00020, 4'h4, 32'h00AA0000, lat, rd);
      ref_write(0, 18'h00020, 4'h4, 32'h00AA0000);
      total++;
      if ({mon_ce_first, mon_lb_first, mon_ub_first} !== 6'b01_01_11) begin
         bad++; $display("FAIL lane_enables: got ce=%b lb=%b ub=%b want 01 01 11", mon_ce_first, mon_lb_first, mon_ub_first);
      end
      access(0, 1, 1'b0, 18'h00020, 4'hF, 32'h0, lat, rd);
      total++;
      if (rd !== ref_mem[0][8'h20]) begin bad++; $display("FAIL lane_readback: got %h want %h", rd, ref_mem[0][8'h20]); end
   endtask

   task automatic test_be_zero();
      int lat;
      logic [31:0] rd;
      access(0, 0, 1'b1, 18'h00040, 4'h0, 32'hCAFEF00D, lat, rd);
      total++; if (lat != 3) begin bad++; $display("FAIL be0_ack: got lat=%0d want 3", lat); end
      total++;
      if (mon_ce_and !== 2'b11 || mon_we_low != 0) begin
         bad++; $display("FAIL be0_strobes: got ce_and=%b we_low=%0d want 11 0", mon_ce_and, mon_we_low);
      end
      access(0, 0, 1'b0, 18'h00040, 4'hF, 32'h0, lat, rd);
      total++;
      if (rd !== ref_mem[0][8'h40]) begin bad++; $display("FAIL be0_readback: got %h want %h", rd, ref_mem[0][8'h40]); end
   endtask

   task automatic test_wait3();
      int lat;
      logic [31:0] rd;
      access(1, 0, 1'b0, 18'h00010, 4'hF, 32'h0, lat, rd);
      total++; if (lat != 5) begin bad++; $display("FAIL w3_latency: got %0d want 5", lat); end
      total++; if (mon_oe_low != 4) begin bad++; $display("FAIL w3_oe_low: got %0d want 4", mon_oe_low); end
      total++;
      if (rd !== ref_mem[1][8'h10]) begin bad++; $display("FAIL w3_rdata: got %h want %h", rd, ref_mem[1][8'h10]); end
   endtask

   task automatic test_fair();
      int na, t, last_t, nb0, nb1;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 2; p++) begin
            we[i][p] = 1'b0; be[i][p] = 4'hF; addr[i][p] = 18'(p * 8 + i); req[i][p] = 1'b1;
         end
      end
      na = 0; t = 0; last_t = -1; nb0 = 0; nb1 = 0;
      while (na < 8 && t < 200) begin
         @(posedge clk); #1;
         t++;
         for (int p = 0; p < 2; p++) begin
            if (ack[0][p]) begin
               total++;
               if (p != na % 2) begin bad++; $display("FAIL fair_order: ack %0d got port %0d want %0d", na, p, na % 2); end
               total++;
               if (t - last_t != ((last_t < 0) ? t - last_t - 1 + 3 - t + 1 + last_t + t - 3 : 4) && last_t >= 0) begin
                  bad++; $display("FAIL fair_period: got %0d want 4", t - last_t);
               end else if (last_t < 0 && t != 3) begin
                  bad++; $display("FAIL fair_first: got cycle %0d want 3", t);
               end
               last_t = t;
               na++;
            end
         end
         if (ack[1][0]) nb0++;
         if (ack[1][1]) nb1++;
      end
      for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) req[i][p] = 1'b0;
      total++; if (na != 8) begin bad++; $display("FAIL fair_count: got %0d acks want 8", na); end
      total++;
      if (nb1 != 0 || nb0 == 0) begin bad++; $display("FAIL fixed_prio: got m0=%0d m1=%0d want m0>0 m1=0", nb0, nb1); end
      do_reset();
   endtask

   task automatic test_reset_abort();
      int lat;
      logic [31:0] rd;
      bit seen, got_ack;
      @(posedge clk); #1;
      we[0][0] = 1'b1; addr[0][0] = 18'h00030; be[0][0] = 4'hF; wdata[0][0] = 32'h12345678; req[0][0] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         @(posedge clk); #1;
         if (ram_we_n[0] === 1'b0) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL abort_strobe: got no we_n low want low"); end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({ram_ce_n[0], ram_ub_n[0], ram_lb_n[0], ram_we_n[0], ram_oe_n[0], ram_dio[0]} !== 9'b111111110) begin
         bad++;
         $display("FAIL abort_ctrl: got %b want 111111110",
                  {ram_ce_n[0], ram_ub_n[0], ram_lb_n[0], ram_we_n[0], ram_oe_n[0], ram_dio[0]});
      end
      got_ack = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack[0][0]) got_ack = 1'b1;
      end
      req[0][0] = 1'b0;
      reset_n = 1'b1;
      last_a = 1;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack[0][0]) got_ack = 1'b1;
      end
      total++; if (got_ack) begin bad++; $display("FAIL abort_ack: got ack want none"); end
      access(0, 0, 1'b1, 18'h00030, 4'hF, 32'h12345678, lat, rd);
      ref_write(0, 18'h00030, 4'hF, 32'h12345678);
      total++; if (lat != 3) begin bad++; $display("FAIL abort_reissue: got lat=%0d want 3", lat); end
   endtask

   task automatic test_random(input int i);
      int lat, p, wc;
      logic w;
      logic [17:0] a;
      logic [3:0] b;
      logic [31:0] d, rd, exp;
      wc = (i == 0) ? 1 : 3;
      for (int k = 0; k < 20; k++) begin
         p = int'($urandom_range(1, 0));
         w = 1'($urandom_range(1, 0));
         a = (k == 0) ? 18'd0 : (k == 1) ? 18'd255 : 18'($urandom_range(255, 0));
         b = w ? 4'($urandom) : 4'hF;
         d = $urandom;
         exp = ref_mem[i][a[7:0]];
         access(i, p, w, a, b, d, lat, rd);
         total++;
         if (lat != 2 + wc) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, 2 + wc); end
         total++;
         if (w) begin
            ref_write(i, a, b, d);
            if (mon_we_low != ((b != 4'h0) ? wc : 0)) begin
               bad++; $display("FAIL rnd_we_low[%0d]: got %0d want %0d", i, mon_we_low, (b != 4'h0) ? wc : 0);
            end
         end else if (rd !== exp) begin
            bad++; $display("FAIL rnd_rdata[%0d]: addr %h got %h want %h", i, a, rd, exp);
         end
         total++;
         if (mon_conflict !== 1'b0) begin bad++; $display("FAIL rnd_conflict[%0d]: got 1 want 0", i); end
      end
   endtask

   task automatic test_pair();
      int t, first, second, q;
      int ta [2];
      logic [31:0] rdv [2];
      logic [31:0] exp;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            we[0][p] = 1'($urandom_range(1, 0));
            addr[0][p] = 18'($urandom_range(127, 0) + 128 * p);
            be[0][p] = we[0][p] ? 4'($urandom) : 4'hF;
            wdata[0][p] = $urandom;
            ta[p] = -1;
            rdv[p] = '0;
         end
         first = (last_a == 0) ? 1 : 0;
         second = 1 - first;
         req[0][0] = 1'b1; req[0][1] = 1'b1;
         t = 0;
         while ((ta[0] < 0 || ta[1] < 0) && t < 40) begin
            @(posedge clk); #1;
            t++;
            for (int p = 0; p < 2; p++) begin
               if (ack[0][p] && ta[p] < 0) begin
                  ta[p] = t; rdv[p] = rdata[0][p]; req[0][p] = 1'b0;
               end
            end
         end
         req[0][0] = 1'b0; req[0][1] = 1'b0;
         $display("txn pair k=%0d first=%0d ack0=%0d ack1=%0d", k, first, ta[0], ta[1]);
         total++;
         if (ta[first] != 3 || ta[second] != 7) begin
            bad++; $display("FAIL pair_grant: got winner@%0d loser@%0d want 3 7 (winner port %0d)", ta[first], ta[second], first);
         end
         for (int o = 0; o < 2; o++) begin
            q = (o == 0) ? first : second;
            if (we[0][q]) begin
               ref_write(0, addr[0][q], be[0][q], wdata[0][q]);
            end else begin
               exp = ref_mem[0][addr[0][q][7:0]];
               total++;
               if (rdv[q] !== exp) begin bad++; $display("FAIL pair_rdata: port %0d got %h want %h", q, rdv[q], exp); end
            end
         end
         last_a = second;
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lane();
      test_be_zero();
      test_wait3();
      test_fair();
      test_reset_abort();
      test_random(0);
      test_random(1);
      test_pair();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
